// File: rtl/ahb_pkg.sv
// Shared types and constants for the two-port AHB-lite master arbiter.
package ahb_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} ahb_owner_t;

  localparam int AHB_AW           = 32;
  localparam int AHB_DW           = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  // Saturating 32-bit increment shared by the statistics counters
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ahb_arb_stats.sv
// Saturating grant/stall counters for ahb_master_arb; only instantiated
// when AHB_ARB_STATS_EN is defined.
module ahb_arb_stats
  import ahb_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_i_gnt,
  input  logic        i_d_gnt,
  input  logic        i_stall,
  output logic [31:0] o_i_grants,
  output logic [31:0] o_d_grants,
  output logic [31:0] o_stalls
);

  logic [31:0] r_i_grants;
  logic [31:0] r_d_grants;
  logic [31:0] r_stalls;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_i_grants <= '0;
      r_d_grants <= '0;
      r_stalls   <= '0;
    end else begin
      if (i_i_gnt) r_i_grants <= sat_inc32(r_i_grants);
      if (i_d_gnt) r_d_grants <= sat_inc32(r_d_grants);
      if (i_stall) r_stalls   <= sat_inc32(r_stalls);
    end
  end

  assign o_i_grants = r_i_grants;
  assign o_d_grants = r_d_grants;
  assign o_stalls   = r_stalls;

endmodule

// File: rtl/ahb_master_arb.sv
// Merges instruction-fetch and data ports onto one AHB-lite bus with data
// priority and a starvation limit. Define AHB_ARB_STATS_EN for counters.
module ahb_master_arb #(
  parameter int          STARVE_LIMIT = ahb_pkg::STARVE_LIMIT_DEF,
  parameter logic [31:0] IDLE_ADDR    = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA
`ifdef AHB_ARB_STATS_EN
  ,
  output logic [31:0] stat_i_grants,
  output logic [31:0] stat_d_grants,
  output logic [31:0] stat_stalls
`endif
);

  import ahb_pkg::*;

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  logic       w_i_win;
  logic       w_i_gnt;
  logic       w_d_gnt;
  logic       w_d_wr;
  logic [3:0] r_starve;

  ahb_owner_t  r_dp_owner;
  logic        r_dp_write;
  logic [31:0] r_dp_wdata;

  // Grants are suppressed while reset is asserted so nothing reaches the bus
  always_comb begin
    w_i_win = i_req & (~d_req | (r_starve == LP_LIMIT));
    w_i_gnt = HRESETn & w_i_win;
    w_d_gnt = HRESETn & d_req & ~w_i_win;
    w_d_wr  = w_d_gnt & d_we;
  end

  assign i_gnt  = w_i_gnt;
  assign d_gnt  = w_d_gnt;
  assign HWRITE = w_d_wr;
  assign HADDR  = w_i_gnt ? i_addr : (w_d_gnt ? d_addr : IDLE_ADDR);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_starve <= '0;
    end else if (w_i_gnt || !i_req) begin
      r_starve <= '0;
    end else if (w_d_gnt && (r_starve != LP_LIMIT)) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  // Data-phase bookkeeping; wdata is zeroed for non-write phases
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_dp_owner <= OWN_NONE;
      r_dp_write <= 1'b0;
      r_dp_wdata <= '0;
    end else begin
      r_dp_owner <= w_i_gnt ? OWN_I : (w_d_gnt ? OWN_D : OWN_NONE);
      r_dp_write <= w_d_wr;
      r_dp_wdata <= w_d_wr ? d_wdata : '0;
    end
  end

  assign HWDATA   = r_dp_wdata;
  assign i_rvalid = (r_dp_owner == OWN_I);
  assign d_rvalid = (r_dp_owner == OWN_D) & ~r_dp_write;
  assign i_rdata  = HRDATA;
  assign d_rdata  = HRDATA;

`ifdef AHB_ARB_STATS_EN
  logic w_stall;
  assign w_stall = (i_req & ~w_i_gnt) | (d_req & ~w_d_gnt);

  ahb_arb_stats u_stats (
    .i_clk      (HCLK),
    .i_rst_n    (HRESETn),
    .i_i_gnt    (w_i_gnt),
    .i_d_gnt    (w_d_gnt),
    .i_stall    (w_stall),
    .o_i_grants (stat_i_grants),
    .o_d_grants (stat_d_grants),
    .o_stalls   (stat_stalls)
  );
`endif

endmodule

// File: doc/ahb_master_arb.md
# ahb_master_arb

Two-port AHB-lite bus master that merges the processor's instruction-fetch port and data load/store port onto the single `ahb_lite` bus. Drives `HADDR`/`HWRITE` in the address phase and `HWDATA` in the following data phase. Returns `HRDATA` to whichever port owns that data phase. Arbitration uses fixed data-port priority with a starvation limit, giving one transfer per cycle when the bus is back-to-back busy.

## Interface

Parameters:
- `STARVE_LIMIT`, 4: after this many consecutive data grants with `i_req` pending, the instruction port wins the next cycle; range 1–15.
- `IDLE_ADDR`, 32'h0000_0000: value driven on `HADDR` when no port is granted.

Ports:
- `HCLK` in 1: bus clock; single clock domain.
- `HRESETn` in 1: reset; synchronous, active-low.
- `i_req` in 1: instruction read request.
- `i_addr` in 32: instruction address, word aligned.
- `i_gnt` out 1: address phase of the instruction request accepted this cycle.
- `i_rvalid` out 1: instruction read data valid.
- `i_rdata` out 32: instruction read data.
- `d_req` in 1: data request.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in 32: data address, word aligned.
- `d_wdata` in 32: write data, sampled in the grant cycle.
- `d_gnt` out 1: data request accepted this cycle.
- `d_rvalid` out 1: data read data valid; reads only.
- `d_rdata` out 32: data read data.
- `HADDR` out 32: bus address.
- `HWRITE` out 1: bus write strobe, address phase.
- `HWDATA` out 32: bus write data, data phase.
- `HRDATA` in 32: bus read data, data phase.

## Operation

- Grant is combinational from the current-cycle requests. `HADDR` and `HWRITE` are muxed from the winner in the same cycle.
- Winner selection:
  - Only one port requesting: that port wins.
  - Both requesting: the data port wins unless `starve_cnt == STARVE_LIMIT`; in that case the instruction port wins.
- `starve_cnt` (4 bits, registered):
  - Increments when the data port wins while `i_req` is high.
  - Clears when the instruction port is granted or `i_req` is low.
  - Saturates at `STARVE_LIMIT`.
- When nothing is granted: `HADDR = IDLE_ADDR`, `HWRITE = 0`. The bus has no HTRANS, so idle cycles are harmless reads that are never returned.
- Data-phase registers, loaded every cycle: `dp_owner` (`OWN_NONE`/`OWN_I`/`OWN_D`), `dp_write`, `dp_wdata`.
- `HWDATA = dp_wdata` at all times. It is 0 whenever the data phase is not a write.
- `i_rvalid = (dp_owner == OWN_I)`.
- `d_rvalid = (dp_owner == OWN_D) & ~dp_write`.
- `i_rdata` and `d_rdata` pass `HRDATA` through. Their contents are don't-care when the matching rvalid is low.
- Writes complete at grant; no write acknowledge is issued.

## Timing

- Request in cycle N with grant in cycle N gives rvalid/rdata in cycle N+1. Read latency is 1 cycle.
- Write: `HADDR`/`HWRITE = 1` in cycle N; `HWDATA = d_wdata` (sampled in N) in cycle N+1.
- Back-to-back grants in N and N+1 give returns in N+1 and N+2. No bubble is inserted between read and write, in either order.
- A requester must hold `req`/`addr`/`we`/`wdata` stable until its `gnt` is high.
- Reset, sampled at a `HCLK` edge with `HRESETn = 0`:
  - `dp_owner = OWN_NONE`, `dp_write = 0`, `dp_wdata = 0`, `starve_cnt = 0`.
  - Therefore `i_rvalid = d_rvalid = 0` and `HWDATA = 0` in the first cycle after reset.
  - A transfer granted in the cycle reset is sampled is dropped: no rvalid is produced.
- While `HRESETn = 0`, `i_gnt = d_gnt = 0` and `HWRITE = 0`.

## Configuration

- `AHB_ARB_STATS_EN` defined adds three output ports, each out 32:
  - `stat_i_grants`: instruction grants.
  - `stat_d_grants`: data grants.
  - `stat_stalls`: cycles where any `req` was high and its `gnt` was low.
  - All three are saturating at 32'hFFFF_FFFF (no wrap) and reset to 0.
- `AHB_ARB_STATS_EN` undefined: these ports and their counter logic are absent. All other behaviour is identical.

## Structure

- `ahb_pkg` holds:
  - `typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} ahb_owner_t`.
  - `AHB_AW = 32` and `AHB_DW = 32`.
  - The `STARVE_LIMIT` default.
- Sub-module `ahb_arb_stats`: the three saturating counters, instantiated only under `AHB_ARB_STATS_EN`.

## Test plan

- **Instruction-only read:** `i_req` with `i_addr = 0x100`; slave returns 0xE3A0_0001 → `i_gnt` in N, `HADDR = 0x100` in N, `i_rvalid` with `i_rdata = 0xE3A0_0001` in N+1, `d_rvalid = 0`.
- **Data write then read to the same address:** write 0xDEAD_BEEF to 0x1_0004 in N, read it in N+1 → `HWRITE = 1` in N, `HWDATA = 0xDEAD_BEEF` in N+1, `d_rvalid` in N+2 with `d_rdata = 0xDEAD_BEEF`.
- **Contention with `STARVE_LIMIT = 4`:** both ports request continuously → data granted in cycles 0–3, instruction in cycle 4, pattern repeats; `i_rvalid` and `d_rvalid` are never high together.
- **Reset mid-transfer:** read granted in N, `HRESETn = 0` sampled at end of N → `d_rvalid = 0` in N+1, `HWRITE = 0`, `HWDATA = 0`, `starve_cnt = 0`.
- **Idle bus:** no requests for 10 cycles → `HADDR = IDLE_ADDR`, `HWRITE = 0`, no rvalid at any point.
- **With `AHB_ARB_STATS_EN`:** 8 cycles of both ports requesting → `stat_d_grants = 7`, `stat_i_grants = 1`, `stat_stalls = 8`; force `stat_stalls` to 32'hFFFF_FFFE, two more stall cycles → value holds at 32'hFFFF_FFFF.
